// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU data-port memory bus: widths, responder state
// encoding and the latched request record.
package mem_bus_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_e;

  // Request fields held for the life of one transaction (index kept separately).
  typedef struct packed {
    logic                  write;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
    logic                  err;
  } mem_req_t;
endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 word storage split into byte lanes: byte-enable write port and a
// registered read port whose output holds until the next read.
module mem_word_array
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      idx,
  input  logic [MEM_DATA_W-1:0] wr_data,
  input  logic [MEM_BE_W-1:0]   wr_be,
  output logic [MEM_DATA_W-1:0] rd_data
);
  for (genvar l = 0; l < MEM_BE_W; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[l]) mem[idx] <= wr_data[8*l +: 8];
      if (rd_en)             rd_data[8*l +: 8] <= mem[idx];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one request at a time, WAIT_CYCLES wait
// states, then a response held until the requester takes it.
module data_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic [MEM_DATA_W-1:0] req_wdata,
  input  logic [MEM_BE_W-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_state_e            state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept, access;
  logic                  req_err;
  mem_req_t              req_q;
  logic [IDX_W-1:0]      idx_q;
  logic [MEM_DATA_W-1:0] rd_data;

  // Full word-index compare so high address bits can never alias into range.
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   (req_addr[MEM_ADDR_W-1:2] >= (MEM_ADDR_W-2)'(DEPTH));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      RSP_IDLE: if (req_valid) begin
        accept    = 1'b1;
        cnt_nxt   = 4'(WAIT_CYCLES);
        state_nxt = RSP_WAIT;
      end
      RSP_WAIT: if (cnt != 4'd0) begin
        cnt_nxt = cnt - 4'd1;
      end else begin
        access    = 1'b1;
        state_nxt = RSP_RESP;
      end
      RSP_RESP: if (rsp_ready) state_nxt = RSP_IDLE;
      default:  state_nxt = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RSP_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      req_q.write <= req_write;
      req_q.wdata <= req_wdata;
      req_q.be    <= req_be;
      req_q.err   <= req_err;
      idx_q       <= req_addr[IDX_W+1:2];
    end
  end

  // Reset has priority over the access edge, so an abandoned store never lands.
  mem_word_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .wr_en   (access && !rst && req_q.write && !req_q.err),
    .rd_en   (access && !rst && !req_q.write && !req_q.err),
    .idx     (idx_q),
    .wr_data (req_q.wdata),
    .wr_be   (req_q.be),
    .rd_data (rd_data)
  );

  assign req_ready = !rst && (state == RSP_IDLE);
  assign rsp_valid = !rst && (state == RSP_RESP);
  assign rsp_err   = rsp_valid && req_q.err;
  assign rsp_rdata = (rsp_valid && !req_q.write && !req_q.err) ? rd_data : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states and
// one with none, selected by sel for each transaction.
module tb_data_mem_responder;
  logic        clk, rst, sel;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [31:0] rd2, rd0;

  logic        rr, rv, re;
  logic [31:0] rdat;
  assign rr   = sel ? rr0 : rr2;
  assign rv   = sel ? rv0 : rv2;
  assign re   = sel ? re0 : re2;
  assign rdat = sel ? rd0 : rd2;

  int n_err = 0, n_chk = 0;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rr2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv2), .rsp_ready(rsp_ready && !sel), .rsp_rdata(rd2), .rsp_err(re2)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rr0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv0), .rsp_ready(rsp_ready && sel), .rsp_rdata(rd0), .rsp_err(re0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (rr !== 1'b1 && k < 20) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    if (k >= 20) chk("ready_timeout", 32'(rr), 32'd1);
  endtask

  // Issue one request from a negedge; returns response and edges from accept to rsp_valid.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic e, output int lat);
    bit got = 0;
    wait_ready();
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (rv === 1'b1) got = 1;
    end
    if (!got) chk("rsp_timeout", 32'(rv), 32'd1);
    rd = rdat;
    e  = re;
    // Competing request offered while the response is stalled must be ignored.
    if (hold > 0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(rv), 32'd1);
      chk("hold_rdata", rdat, rd);
      chk("hold_req_ready", 32'(rr), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("hs_rsp_drop", 32'(rv), 32'd0);
    chk("hs_req_ready", 32'(rr), 32'd1);
  endtask

  // Start a store and reset the responder while it sits in WAIT.
  task automatic rst_in_wait(input logic [31:0] a, input logic [31:0] wd);
    int seen = 0;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = wd; req_be = 4'hF;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstw_req_ready", 32'(rr), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (rv === 1'b1) seen++;
    end
    chk("rstw_no_rsp", 32'(seen), 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

    // Reset
    @(negedge clk); @(posedge clk); @(negedge clk);
    chk("rst_req_ready", 32'(rr), 32'd0);
    chk("rst_rsp_valid", 32'(rv), 32'd0);
    chk("rst_rsp_err", 32'(re), 32'd0);
    chk("rst_rsp_rdata", rdat, 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_req_ready", 32'(rr), 32'd1);
    chk("post_rst_rsp_valid", 32'(rv), 32'd0);
    chk("post_rst_rsp_err", 32'(re), 32'd0);

    // Store / load round trip, latency 1+2
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, e, lat);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_err", 32'(e), 32'd0);
    chk("st_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_rdata", rd, 32'hDEAD_BEEF);
    chk("ld_err", 32'(e), 32'd0);

    // Partial byte write
    do_req(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, rd, e, lat);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("be1_rdata", rd, 32'hDEAD_BEAA);

    // be=0 store leaves the word alone
    do_req(1'b1, 32'h10, 32'h5555_5555, 4'b0000, 0, rd, e, lat);
    chk("be0_err", 32'(e), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("be0_rdata", rd, 32'hDEAD_BEAA);

    // Errors
    do_req(1'b0, 32'h12, 32'h0, 4'h0, 0, rd, e, lat);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_lat", 32'(lat), 32'd3);
    do_req(1'b0, 32'h400, 32'h0, 4'h0, 0, rd, e, lat);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    do_req(1'b1, 32'h0, 32'h1122_3344, 4'hF, 0, rd, e, lat);
    do_req(1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, 0, rd, e, lat);
    chk("oor_st_err", 32'(e), 32'd1);
    do_req(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, rd, e, lat);
    chk("alias_st_err", 32'(e), 32'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, e, lat);
    chk("oor_word0", rd, 32'h1122_3344);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("alias_word10", rd, 32'hDEAD_BEAA);

    // Stalled response with a competing request
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, e, lat);
    chk("hold_ld_rdata", rd, 32'hDEAD_BEAA);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("hold_no_write", rd, 32'hDEAD_BEAA);

    // Reset during WAIT abandons the store
    do_req(1'b1, 32'h20, 32'h0, 4'hF, 0, rd, e, lat);
    rst_in_wait(32'h20, 32'h1234_5678);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat);
    chk("rstw_rdata", rd, 32'h0);

    // Zero wait states
    sel = 1'b1;
    @(posedge clk); @(negedge clk);
    do_req(1'b1, 32'h20, 32'h0, 4'hF, 0, rd, e, lat);
    chk("w0_st_lat", 32'(lat), 32'd1);
    rst_in_wait(32'h20, 32'h1234_5678);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat);
    chk("w0_ld_lat", 32'(lat), 32'd1);
    chk("w0_rstw_rdata", rd, 32'h0);
    do_req(1'b1, 32'h24, 32'hA5A5_0F0F, 4'hF, 0, rd, e, lat);
    do_req(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, e, lat);
    chk("w0_ld_rdata", rd, 32'hA5A5_0F0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
